ifu_fetch: RTL and testbench

Instruction-fetch front end of the pipelined MIPS core. Holds the fetch PC, issues word requests to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue toward the decode stage. It consumes the next-PC redirect (taken branch, jump, `jr` target) and discards wrong-path fetches.

---
 rtl/ifu_fetch.sv | 106 ++++++++++
 tb/tb_ifu_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, runs the imem req/ack handshake,
// and keeps a 2-entry {inst, pc} queue in front of decode. Redirects flush and restart.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc4,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } qent_t;

  state_t          state;
  logic [31:0]     pc;
  logic [1:0]      count;
  qent_t [1:0]     q;

  logic            pop, push, push_idx;
  logic [1:0]      cnt_next;
  logic [31:0]     tgt, pc_inc;

  // Head of the queue is always slot 0; slot 1 shifts down on pop.
  assign inst_valid = (count != 2'd0);
  assign inst       = q[0].inst;
  assign inst_pc    = q[0].pc;
  assign pc4        = inst_pc + 32'd4;

  assign pop    = inst_valid & inst_ready;
  assign push   = (state == REQ) & imem_req & imem_ack & ~redirect_valid;
  assign tgt    = redirect_pc & ~32'd3;
  assign pc_inc = pc + 32'd4;

  always_comb begin
    cnt_next = count;
    if (push && !pop)      cnt_next = count + 2'd1;
    else if (!push && pop) cnt_next = count - 2'd1;
    push_idx = pop ? (count == 2'd2) : (count == 2'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      count     <= 2'd0;
      q         <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      // Queue storage; a push into slot 0 overrides the shift when both happen.
      if (pop)  q[0] <= q[1];
      if (push) q[push_idx] <= '{inst: imem_rdata, pc: imem_addr};
      count <= redirect_valid ? 2'd0 : cnt_next;

      if (redirect_valid) begin
        pc <= tgt;
        // An unanswered request must be allowed to finish before the target goes out.
        if (imem_req && !imem_ack) begin
          state <= DROP;
        end else begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= tgt;
        end
      end else begin
        case (state)
          IDLE: if (cnt_next < 2'd2) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
          REQ: if (imem_ack) begin
            pc <= pc_inc;
            if (cnt_next < 2'd2) begin
              imem_addr <= pc_inc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
          DROP: if (imem_ack) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: expected inst_pc sequences are queued by the stimulus,
// a negedge monitor pops and checks them on every decode handshake.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, pc4;
  logic        inst_ready = 1'b0;

  int tests = 0, fails = 0;
  int nwait = 0, wcnt = 0, cyc = 0, last_acc = -1, exp_gap = 0;
  bit hold = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] mon_e, prev_addr;
  logic        prev_req = 1'b0, prev_ack = 1'b0;

  ifu_fetch dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc4(pc4),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // Memory returns ~addr after nwait wait cycles; hold stalls the ack indefinitely.
  assign imem_rdata = ~imem_addr;
  always @(posedge clk) begin
    cyc++;
    #2;
    if (imem_req && !hold && wcnt >= nwait) begin
      imem_ack = 1'b1;
      wcnt = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) wcnt++; else wcnt = 0;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack) begin
        chk("req_hold", {31'd0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
        end else begin
          mon_e = sb.pop_front();
          chk("inst_pc", inst_pc, mon_e);
          chk("inst", inst, ~mon_e);
          chk("pc4", pc4, mon_e + 32'd4);
          if (exp_gap != 0 && last_acc >= 0) chk("gap", 32'(cyc - last_acc), 32'(exp_gap));
          last_acc = cyc;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; hold = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_pc4", pc4, 32'd4);
    tick(2);
    reset_n = 1'b1;
    last_acc = -1;
  endtask

  task automatic drain(string nm);
    for (int k = 0; k < 300 && sb.size() != 0; k++) tick(1);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d pending expected 0", nm, sb.size());
    end
    sb.delete();
    inst_ready = 1'b0;
  endtask

  task automatic wait_addr(logic [31:0] a);
    int k;
    for (k = 0; k < 100; k++) begin
      tick(1);
      if (imem_req && imem_addr == a) break;
    end
    tests++;
    if (k == 100) begin
      fails++;
      $display("FAIL wait_addr: got timeout expected req to %h", a);
    end
  endtask

  initial begin
    // Zero-wait streaming: one instruction per cycle.
    do_reset();
    nwait = 0; exp_gap = 1;
    sb.push_back(32'h3000); sb.push_back(32'h3004); sb.push_back(32'h3008);
    sb.push_back(32'h300c); sb.push_back(32'h3010);
    inst_ready = 1'b1;
    drain("zero_wait");
    exp_gap = 0;

    // Three wait cycles: one instruction every 4 cycles.
    do_reset();
    nwait = 3; exp_gap = 4;
    sb.push_back(32'h3000); sb.push_back(32'h3004); sb.push_back(32'h3008);
    sb.push_back(32'h300c); sb.push_back(32'h3010);
    inst_ready = 1'b1;
    drain("wait3");
    exp_gap = 0;

    // Decode stalled: queue fills to 2 and requests stop.
    do_reset();
    nwait = 0;
    tick(6);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_head", inst_pc, 32'h3000);
    sb.push_back(32'h3000); sb.push_back(32'h3004);
    sb.push_back(32'h3008); sb.push_back(32'h300c);
    inst_ready = 1'b1;
    drain("stall");

    // Redirect while 0x3008 is waiting: old response dropped.
    do_reset();
    nwait = 3;
    sb.push_back(32'h3000); sb.push_back(32'h3004);
    sb.push_back(32'h4010); sb.push_back(32'h4014); sb.push_back(32'h4018);
    inst_ready = 1'b1;
    wait_addr(32'h3008);
    hold = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4010;
    tick(1);
    redirect_valid = 1'b0;
    chk("drop_addr", imem_addr, 32'h3008);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_flush", {31'd0, inst_valid}, 32'd0);
    tick(2);
    hold = 1'b0;
    drain("drop");

    // Redirect to unaligned target in the same cycle as an ack.
    do_reset();
    nwait = 0;
    tick(4);
    nwait = 2;
    sb.push_back(32'h3000);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(posedge clk); #3;
        if (imem_ack) break;
      end
      tests++;
      if (k == 20) begin
        fails++;
        $display("FAIL ack_wait: got timeout expected ack");
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4013;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir_ack_addr", imem_addr, 32'h4010);
    chk("redir_ack_req", {31'd0, imem_req}, 32'd1);
    chk("redir_ack_flush", {31'd0, inst_valid}, 32'd0);
    sb.push_back(32'h4010); sb.push_back(32'h4014); sb.push_back(32'h4018);
    inst_ready = 1'b1;
    drain("redir_ack");

    // Address wrap at the top of memory.
    do_reset();
    nwait = 0;
    tick(4);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0004); sb.push_back(32'h0000_0008);
    inst_ready = 1'b1;
    drain("wrap");

    // Reset asserted with a request outstanding.
    do_reset();
    nwait = 5;
    tick(2);
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
